// File: rtl/sync_long_pkg.sv
// Shared constants and FSM state encodings for the long-sync / symbol-buffer chain.
package sync_long_pkg;

    localparam int SYM_LEN    = 64;
    localparam int CP_LEN     = 16;
    localparam int DATA_WIDTH = 16;

    typedef enum logic {
        W_FILL    = 1'b0,
        W_DISCARD = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_STREAM = 1'b1
    } rd_state_t;

endpackage

// File: rtl/sym_bank.sv
// One symbol bank: SYM_LEN I/Q registers with a write port, indexed read, full flag and tag.
module sym_bank #(
    parameter int DATA_WIDTH = sync_long_pkg::DATA_WIDTH,
    parameter int SYM_LEN    = sync_long_pkg::SYM_LEN
) (
    input  logic                       CLK,
    input  logic                       s_RST,
    input  logic                       wr_en,
    input  logic [$clog2(SYM_LEN)-1:0] wr_idx,
    input  logic [DATA_WIDTH-1:0]      wr_I,
    input  logic [DATA_WIDTH-1:0]      wr_Q,
    input  logic                       tag_we,
    input  logic                       tag_in,
    input  logic                       set_full,
    input  logic                       clr_full,
    input  logic [$clog2(SYM_LEN)-1:0] rd_idx,
    output logic [DATA_WIDTH-1:0]      rd_I,
    output logic [DATA_WIDTH-1:0]      rd_Q,
    output logic                       full,
    output logic                       tag
);

    logic [2*DATA_WIDTH-1:0] mem [SYM_LEN];

    // NOTE: sample storage is deliberately not reset; the full flag alone
    // decides whether its contents are meaningful, so clearing it is wasted logic.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_idx] <= {wr_I, wr_Q};
        end
    end

    // A free and a fill in the same cycle resolve as free-then-fill.
    always_ff @(posedge CLK) begin
        if (s_RST) begin
            full <= 1'b0;
            tag  <= 1'b0;
        end else begin
            full <= (full & ~clr_full) | set_full;
            if (tag_we) begin
                tag <= tag_in;
            end
        end
    end

    assign {rd_I, rd_Q} = mem[rd_idx];

endmodule

// File: rtl/symbol_buffer_pingpong.sv
// Ping-pong symbol buffer between the long-sync phase corrector and the 64-point FFT;
// collects SYM_LEN-sample symbols and streams them out over valid/ready, tagged long/data.
module symbol_buffer_pingpong
    import sync_long_pkg::*;
#(
    parameter int DATA_WIDTH    = sync_long_pkg::DATA_WIDTH,
    parameter int SYM_LEN       = sync_long_pkg::SYM_LEN,
    parameter int SYM_CNT_WIDTH = 8
) (
    input  logic                       CLK,
    input  logic                       s_RST,
    input  logic                       in_frame_reset,
    input  logic                       in_strobe,
    input  logic [DATA_WIDTH-1:0]      in_I,
    input  logic [DATA_WIDTH-1:0]      in_Q,
    input  logic                       in_long,
    input  logic                       in_stream,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_I,
    output logic [DATA_WIDTH-1:0]      out_Q,
    output logic [$clog2(SYM_LEN)-1:0] out_index,
    output logic                       out_last,
    output logic                       out_is_long,
    output logic [SYM_CNT_WIDTH-1:0]   out_sym_count,
    output logic                       overflow
);

    localparam int IDX_W = $clog2(SYM_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYM_LEN - 1);

    logic clr;
    logic acc;
    logic qual_drop;

    wr_state_t        wr_state, wr_state_nxt;
    logic [IDX_W-1:0] wr_ptr, wr_ptr_nxt;
    logic             wr_bank, wr_bank_nxt;
    logic             overflow_nxt;
    logic             wr_en;
    logic             wr_last;
    logic             wr_avail;

    rd_state_t                rd_state, rd_state_nxt;
    logic [IDX_W-1:0]         rd_ptr, rd_ptr_nxt;
    logic                     rd_bank, rd_bank_nxt;
    logic [SYM_CNT_WIDTH-1:0] sym_cnt, sym_cnt_nxt;
    logic                     xfer;
    logic                     rd_last;

    logic [1:0]                 bank_full;
    logic [1:0]                 bank_tag;
    logic [1:0][DATA_WIDTH-1:0] bank_rd_I;
    logic [1:0][DATA_WIDTH-1:0] bank_rd_Q;

    assign clr       = s_RST | in_frame_reset;
    assign acc       = in_strobe & (in_long | in_stream);
    assign qual_drop = ~in_long & ~in_stream & (wr_ptr != '0);

    assign xfer    = (rd_state == R_STREAM) & out_ready;
    assign rd_last = xfer & (rd_ptr == LAST_IDX);

    // The bank being freed this cycle counts as available to a new symbol.
    assign wr_avail = ~bank_full[wr_bank] | (rd_last & (rd_bank == wr_bank));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        sym_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .SYM_LEN    (SYM_LEN)
        ) u_bank (
            .CLK      (CLK),
            .s_RST    (clr),
            .wr_en    (wr_en & (wr_bank == 1'(b))),
            .wr_idx   (wr_ptr),
            .wr_I     (in_I),
            .wr_Q     (in_Q),
            .tag_we   (wr_en & (wr_bank == 1'(b)) & (wr_ptr == '0)),
            .tag_in   (in_long),
            .set_full (wr_last & (wr_bank == 1'(b))),
            .clr_full (rd_last & (rd_bank == 1'(b))),
            .rd_idx   (rd_ptr),
            .rd_I     (bank_rd_I[b]),
            .rd_Q     (bank_rd_Q[b]),
            .full     (bank_full[b]),
            .tag      (bank_tag[b])
        );
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        wr_state_nxt = wr_state;
        wr_ptr_nxt   = wr_ptr;
        wr_bank_nxt  = wr_bank;
        overflow_nxt = overflow;
        wr_en        = 1'b0;
        wr_last      = 1'b0;
        case (wr_state)
            W_FILL: begin
                if (qual_drop) begin
                    wr_ptr_nxt = '0;
                end else if (acc) begin
                    if ((wr_ptr == '0) && !wr_avail) begin
                        // This strobe is the first of the discarded symbol.
                        wr_state_nxt = W_DISCARD;
                        wr_ptr_nxt   = IDX_W'(1);
                        overflow_nxt = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr + IDX_W'(1);
                        if (wr_ptr == LAST_IDX) begin
                            wr_last     = 1'b1;
                            wr_bank_nxt = ~wr_bank;
                        end
                    end
                end
            end
            W_DISCARD: begin
                // wr_ptr doubles as the discard counter; a qualifier drop is a symbol boundary.
                if (qual_drop) begin
                    wr_ptr_nxt   = '0;
                    wr_state_nxt = W_FILL;
                end else if (acc) begin
                    wr_ptr_nxt   = wr_ptr + IDX_W'(1);
                    overflow_nxt = 1'b1;
                    if (wr_ptr == LAST_IDX) begin
                        wr_state_nxt = W_FILL;
                    end
                end
            end
            default: begin
                wr_state_nxt = W_FILL;
                wr_ptr_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        rd_state_nxt = rd_state;
        rd_ptr_nxt   = rd_ptr;
        rd_bank_nxt  = rd_bank;
        sym_cnt_nxt  = sym_cnt;
        case (rd_state)
            R_IDLE: begin
                if (bank_full[rd_bank]) begin
                    rd_state_nxt = R_STREAM;
                    rd_ptr_nxt   = '0;
                end
            end
            R_STREAM: begin
                if (xfer) begin
                    rd_ptr_nxt = rd_ptr + IDX_W'(1);
                end
                if (rd_last) begin
                    rd_bank_nxt = ~rd_bank;
                    if (sym_cnt != '1) begin
                        sym_cnt_nxt = sym_cnt + 1'b1;
                    end
                    // Other bank already waiting: continue with no bubble.
                    if (!bank_full[~rd_bank]) begin
                        rd_state_nxt = R_IDLE;
                    end
                end
            end
            default: begin
                rd_state_nxt = R_IDLE;
                rd_ptr_nxt   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (clr) begin
            wr_state <= W_FILL;
            wr_ptr   <= '0;
            wr_bank  <= 1'b0;
            overflow <= 1'b0;
            rd_state <= R_IDLE;
            rd_ptr   <= '0;
            rd_bank  <= 1'b0;
            sym_cnt  <= '0;
        end else begin
            wr_state <= wr_state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            wr_bank  <= wr_bank_nxt;
            overflow <= overflow_nxt;
            rd_state <= rd_state_nxt;
            rd_ptr   <= rd_ptr_nxt;
            rd_bank  <= rd_bank_nxt;
            sym_cnt  <= sym_cnt_nxt;
        end
    end

    assign out_valid     = (rd_state == R_STREAM);
    assign out_I         = out_valid ? bank_rd_I[rd_bank] : '0;
    assign out_Q         = out_valid ? bank_rd_Q[rd_bank] : '0;
    assign out_index     = rd_ptr;
    assign out_last      = out_valid & (rd_ptr == LAST_IDX);
    assign out_is_long   = out_valid & bank_tag[rd_bank];
    assign out_sym_count = sym_cnt;

endmodule

// File: tb/tb_symbol_buffer_pingpong.sv
// Bench for symbol_buffer_pingpong: directed scenarios plus random traffic against a
// queue-based model of a two-symbol buffer with discard on overflow.
module tb_symbol_buffer_pingpong;

    localparam int DW = 16;
    localparam int SL = 64;

    logic          CLK = 1'b0;
    logic          s_RST = 1'b1;
    logic          in_frame_reset = 1'b0;
    logic          in_strobe = 1'b0;
    logic [DW-1:0] in_I = '0;
    logic [DW-1:0] in_Q = '0;
    logic          in_long = 1'b0;
    logic          in_stream = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_I;
    logic [DW-1:0] out_Q;
    logic [5:0]    out_index;
    logic          out_last;
    logic          out_is_long;
    logic [7:0]    out_sym_count;
    logic          overflow;

    always #5 CLK = ~CLK;

    symbol_buffer_pingpong #(
        .DATA_WIDTH    (DW),
        .SYM_LEN       (SL),
        .SYM_CNT_WIDTH (8)
    ) dut (
        .CLK            (CLK),
        .s_RST          (s_RST),
        .in_frame_reset (in_frame_reset),
        .in_strobe      (in_strobe),
        .in_I           (in_I),
        .in_Q           (in_Q),
        .in_long        (in_long),
        .in_stream      (in_stream),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_I          (out_I),
        .out_Q          (out_Q),
        .out_index      (out_index),
        .out_last       (out_last),
        .out_is_long    (out_is_long),
        .out_sym_count  (out_sym_count),
        .overflow       (overflow)
    );

    typedef struct {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
        int            idx;
        logic          lng;
    } samp_t;

    samp_t       exp_q[$];   // samples of complete symbols awaiting delivery
    samp_t       part_q[$];  // symbol currently being collected
    samp_t       s;
    int          held;       // complete symbols not yet fully delivered (capacity 2)
    int          m_count;
    bit          m_ovf;
    bit          discarding;
    int          disc_cnt;
    int          total;
    int          bad;
    logic [DW-1:0] first_I;
    bit          p_stall;
    logic [63:0] p_snap;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Model and monitor: inputs are stable here and the next posedge consumes them.
    always @(negedge CLK) begin
        if (!s_RST) begin
            check("sym_count", out_sym_count, m_count);
            check("overflow", overflow, m_ovf);
            if (p_stall)
                check("stall_hold", {out_valid, out_I, out_Q, out_index, out_is_long},
                      {1'b1, p_snap[38:0]});
        end
        if (s_RST || in_frame_reset) begin
            exp_q.delete();
            part_q.delete();
            held = 0; m_count = 0; m_ovf = 0; discarding = 0; disc_cnt = 0; p_stall = 0;
        end else begin
            if (out_valid)
                check("valid_has_data", exp_q.size() != 0, 1'b1);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                s = exp_q.pop_front();
                check("out_I", out_I, s.i);
                check("out_Q", out_Q, s.q);
                check("out_index", out_index, s.idx);
                check("out_is_long", out_is_long, s.lng);
                check("out_last", out_last, s.idx == SL - 1);
                if (s.idx == 0) first_I = out_I;
                if (s.idx == SL - 1) begin
                    held--;
                    m_count = (m_count == 255) ? 255 : m_count + 1;
                end
            end
            p_stall = out_valid && !out_ready;
            p_snap  = {25'b0, out_valid, out_I, out_Q, out_index, out_is_long};
            if (!in_long && !in_stream) begin
                part_q.delete();
                discarding = 0;
                disc_cnt   = 0;
            end else if (in_strobe) begin
                if (discarding) begin
                    disc_cnt++;
                    if (disc_cnt == SL) begin
                        discarding = 0;
                        disc_cnt   = 0;
                    end
                end else if (part_q.size() == 0 && held == 2) begin
                    discarding = 1;
                    disc_cnt   = 1;
                    m_ovf      = 1;
                end else begin
                    s.i   = in_I;
                    s.q   = in_Q;
                    s.idx = part_q.size();
                    s.lng = (part_q.size() == 0) ? in_long : part_q[0].lng;
                    part_q.push_back(s);
                    if (part_q.size() == SL) begin
                        foreach (part_q[k]) exp_q.push_back(part_q[k]);
                        part_q.delete();
                        held++;
                    end
                end
            end
        end
    end

    task automatic step(input bit stb, input bit lng, input bit strm, input int v);
        in_strobe = stb;
        in_long   = lng;
        in_stream = strm;
        in_I      = DW'(v);
        in_Q      = DW'(-v);
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input int budget);
        out_ready = 1'b1;
        for (int n = 0; n < budget && exp_q.size() != 0; n++) step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int v;
        total = 0; bad = 0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", {out_I, out_Q}, 0);
        check("rst_index", out_index, 0);
        check("rst_flags", {out_last, out_is_long, overflow}, 0);
        check("rst_count", out_sym_count, 0);
        s_RST = 1'b0;
        step(0, 0, 0, 0);

        // 1: two long-training symbols, free-flowing output
        out_ready = 1'b1;
        for (int i = 0; i < 2 * SL; i++) begin
            step(1, 1, 0, i % SL);
            if (i == SL - 1) check("latency_not_early", out_valid, 0);
            if (i == SL) check("latency_valid", out_valid, 1);
        end
        drain(300);
        check("lts_count", out_sym_count, 2);
        check("lts_ovf", overflow, 0);

        // 2: long symbol, CP-style gap, then data symbol
        for (int i = 0; i < SL; i++) step(1, 1, 0, 100 + i);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0);
        for (int i = 0; i < SL; i++) step(1, 0, 1, 200 + i);
        drain(300);
        check("lt_count", out_sym_count, 4);

        // 3: back-pressure over three symbols
        out_ready = 1'b0;
        for (int i = 0; i < 3 * SL; i++) step(1, 0, 1, 300 + i);
        check("bp_ovf", overflow, 1);
        check("bp_valid_held", out_valid, 1);
        drain(400);
        check("bp_count", out_sym_count, 6);

        // 4: partial symbol dropped by a qualifier gap
        v = 0;
        for (int i = 0; i < 30; i++) begin step(1, 0, 1, v); v++; end
        step(0, 0, 0, 0);
        for (int i = 0; i < SL; i++) begin step(1, 0, 1, v); v++; end
        drain(300);
        check("pd_count", out_sym_count, 7);
        check("pd_first", first_I, 30);

        // 5: frame reset in the middle of delivery
        for (int i = 0; i < SL; i++) step(1, 0, 1, 500 + i);
        for (int n = 0; n < 200 && !(out_valid && out_index == 20); n++) step(0, 0, 0, 0);
        check("fr_reached_idx20", {out_valid, out_index}, {1'b1, 6'd20});
        in_frame_reset = 1'b1;
        step(0, 0, 0, 0);
        in_frame_reset = 1'b0;
        check("fr_valid", out_valid, 0);
        check("fr_count", out_sym_count, 0);
        check("fr_ovf", overflow, 0);
        for (int i = 0; i < SL; i++) step(1, 0, 1, 600 + i);
        drain(300);
        check("fr_clean_count", out_sym_count, 1);

        // 6: ready toggling every cycle
        for (int i = 0; i < 2 * SL; i++) begin
            out_ready = i[0];
            step(1, 0, 1, 700 + i);
        end
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
            out_ready = n[0];
            step(0, 0, 0, 0);
        end
        check("tg_empty", exp_q.size(), 0);
        check("tg_count", out_sym_count, 3);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            bit drop;
            in_frame_reset = ($urandom_range(0, 1499) == 0);
            out_ready      = ($urandom_range(0, 9) < 6);
            drop           = ($urandom_range(0, 149) == 0);
            if (drop) step(0, 0, 0, 0);
            else if ($urandom_range(0, 7) == 0) step($urandom_range(0, 9) < 7, 1, 0, int'($urandom));
            else step($urandom_range(0, 9) < 7, 0, 1, int'($urandom));
        end
        in_frame_reset = 1'b0;
        drain(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/symbol_buffer_pingpong.md
Name: symbol_buffer_pingpong

Overview:
- Sits directly downstream of the long-sync FSM/phase-corrector chain and directly upstream of the 64-point FFT.
- Collects CP-stripped, phase-corrected samples into 64-sample symbols in a two-bank (ping-pong) buffer.
- Streams each complete symbol to the FFT over a valid/ready handshake, tagged as long-training or data.
- Keeps 64-sample alignment when the FFT back-pressures.

Parameters:
DATA_WIDTH, 16, width of each I and Q sample (signed two's complement)
SYM_LEN, 64, samples per symbol; must be a power of 2
SYM_CNT_WIDTH, 8, width of the symbol counter

Ports:
CLK  input  1  clock
s_RST  input  1  synchronous reset, active-high
in_frame_reset  input  1  pulse on new short-preamble detection; clears frame state
in_strobe  input  1  sample valid (long-sync Out_Strobe)
in_I  input  DATA_WIDTH  corrected in-phase sample
in_Q  input  DATA_WIDTH  corrected quadrature sample
in_long  input  1  Providing_Long qualifier
in_stream  input  1  Providing_Stream qualifier
out_valid  output  1  output sample valid
out_ready  input  1  FFT ready
out_I  output  DATA_WIDTH  output in-phase sample
out_Q  output  DATA_WIDTH  output quadrature sample
out_index  output  log2(SYM_LEN)  sample index within symbol, 0..SYM_LEN-1
out_last  output  1  high with index SYM_LEN-1
out_is_long  output  1  symbol tag: 1 = long training, 0 = data
out_sym_count  output  SYM_CNT_WIDTH  count of symbols fully delivered since frame reset, saturating
overflow  output  1  sticky; a symbol was discarded

Behaviour:
Reset and frame reset:
- Reset (s_RST, or in_frame_reset when s_RST is low) clears everything.
- Cleared state: both banks empty, wr_ptr=0, rd_ptr=0, wr_bank=0, rd_bank=0, write state W_FILL, read state R_IDLE.
- Cleared outputs: out_valid=0, out_I=0, out_Q=0, out_index=0, out_last=0, out_is_long=0, out_sym_count=0, overflow=0.
- Reset mid-symbol aborts both sides immediately. No partial output.

Accepted sample:
- acc = in_strobe & (in_long | in_stream).

Write FSM:
- W_FILL:
  - On acc: store at mem[wr_bank][wr_ptr] and increment wr_ptr.
  - At wr_ptr=0, latch tag[wr_bank]=in_long.
  - On the write at wr_ptr=SYM_LEN-1: set full[wr_bank], wr_ptr wraps to 0, wr_bank toggles.
  - If the new wr_bank is still full on the next acc, go to W_DISCARD.
- W_DISCARD:
  - Count acc strobes without storing and set overflow.
  - After SYM_LEN strobes, return to W_FILL at a symbol boundary.
  - The same-cycle check "target bank free" is re-evaluated at each symbol start.
- Qualifier drop: if in_long=in_stream=0 while wr_ptr≠0 (partial symbol), reset wr_ptr to 0 and discard the partial data, in both W_FILL and W_DISCARD. This is legal across the CP gap because wr_ptr=0 there.

Read FSM:
- R_IDLE: when full[rd_bank]=1, go to R_STREAM on the next cycle with out_valid=1 and rd_ptr=0.
  - Latency: first out_valid appears 1 cycle after the last write of the symbol.
- R_STREAM:
  - out_I/out_Q = mem[rd_bank][rd_ptr], out_index=rd_ptr, out_is_long=tag[rd_bank].
  - Transfer occurs on out_valid & out_ready; rd_ptr increments on each transfer.
  - On the transfer with rd_ptr=SYM_LEN-1: clear full[rd_bank], toggle rd_bank, increment out_sym_count (saturating at all-ones).
  - If the other bank is already full, stay in R_STREAM with no bubble; otherwise go to R_IDLE.
- Outputs are stable while out_valid & !out_ready.

Boundary conditions:
- Simultaneous free and fill of the same bank in one cycle: the free takes effect first, so the bank counts as available. No discard.
- acc during W_DISCARD's final strobe: counted as a discard, not a write.
- out_ready held high with continuous input: back-to-back symbols, no loss.

Decomposition:
- Shared package (sync_long_pkg) holds:
  - SYM_LEN, CP_LEN=16.
  - The write-state encodings W_FILL/W_DISCARD and read-state encodings R_IDLE/R_STREAM.
  - The shared DATA_WIDTH default.
- Sub-module sym_bank: one SYM_LEN×2·DATA_WIDTH register bank with write port, combinational read by index, full flag and tag register. It is instantiated twice.

Test Plan:
1. LTS capture: in_long=1, 128 strobes carrying I=index, Q=-index, out_ready=1 -> two symbols, out_is_long=1, out_index 0..63, out_last at 63, out_sym_count=2, overflow=0.
2. Long-to-data transition: 64 long strobes, 16-cycle gap with both qualifiers low, then 64 strobes with in_stream=1 -> second symbol has out_is_long=0 and correct data; the gap causes no misalignment.
3. Back-pressure: out_ready=0 throughout 3 symbols (192 strobes) -> symbols 1 and 2 held, symbol 3 discarded, overflow=1. Then raise out_ready -> symbols 1 and 2 delivered intact, out_sym_count=2.
4. Partial drop: 30 strobes with in_stream=1, qualifiers low for 1 cycle, then 64 strobes -> exactly one symbol out, whose first sample is the 31st input.
5. Mid-stream reset: in_frame_reset pulse at out_index=20 -> next cycle out_valid=0, out_sym_count=0, overflow=0. A subsequent 64 strobes give a clean symbol.
6. Stall stability: out_ready toggling 1/0 every cycle -> out_I/out_Q/out_index unchanged during stalls; all 64 samples delivered in order.
